// File: rtl/dff_arb_pkg.sv
// ---------------------------------------------------------------------------
// dff_arb_pkg
// Shared definitions for the round-robin arbitrated shared register:
//   - arb_state_e : controller states (IDLE / GRANT / HOLDING)
//   - DEF_*       : default parameter values for the arbiter
// No ports (package).
// ---------------------------------------------------------------------------
package dff_arb_pkg;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_HOLD  = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        HOLDING = 2'd2
    } arb_state_e;

endpackage

// File: rtl/dff_rr_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin search: returns the first asserted request
// found when scanning upward from rr_ptr_i, wrapping NREQ-1 -> 0.
// Ports:
//   req_i     [NREQ]        request vector
//   rr_ptr_i  [clog2(NREQ)] index where the search starts
//   winner_o  [clog2(NREQ)] selected requester (0 when nothing requests)
//   any_o     [1]           at least one request is asserted
// ---------------------------------------------------------------------------
module rr_picker #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req_i,
    input  logic [$clog2(NREQ)-1:0] rr_ptr_i,
    output logic [$clog2(NREQ)-1:0] winner_o,
    output logic                    any_o
);

    localparam int IW = $clog2(NREQ);

    // One spare bit so ptr + offset can exceed NREQ-1 before wrapping.
    logic [IW:0] idx;

    always_comb begin
        winner_o = '0;
        idx      = '0;
        any_o    = |req_i;
        // Scan offsets from farthest to nearest so the nearest match wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr_i} + (IW + 1)'(k);
            if (idx >= (IW + 1)'(NREQ)) begin
                idx = idx - (IW + 1)'(NREQ);
            end
            if (req_i[idx[IW-1:0]]) begin
                winner_o = idx[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/dff_rr_arbiter.sv
// ---------------------------------------------------------------------------
// dff_rr_arbiter
// Round-robin arbitrated shared data register. One requester at a time is
// granted for a single cycle; its data slice is then latched into q and
// presented with q_valid for HOLD cycles, followed by at least one IDLE
// cycle before the next grant.
// Ports:
//   clk      [1]            clock, all state on rising edge
//   rst_n    [1]            synchronous active-low reset
//   req      [NREQ]         per-requester request (held until own gnt)
//   wdata    [NREQ*WIDTH]   requester i data in [i*WIDTH +: WIDTH]
//   gnt      [NREQ]         registered one-hot grant, one cycle per transaction
//   busy     [1]            high in GRANT and HOLDING
//   q        [WIDTH]        shared register contents
//   q_valid  [1]            q holds a fresh transaction result
//   q_owner  [clog2(NREQ)]  requester whose data is (or will be) in q
// ---------------------------------------------------------------------------
module dff_rr_arbiter
    import dff_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int HOLD  = DEF_HOLD
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   wdata,
    output logic [NREQ-1:0]         gnt,
    output logic                    busy,
    output logic [WIDTH-1:0]        q,
    output logic                    q_valid,
    output logic [$clog2(NREQ)-1:0] q_owner
);

    localparam int IW = $clog2(NREQ);
    // Counter only ever holds HOLD-1 down to 0.
    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

    arb_state_e       state_q, state_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             q_valid_q, q_valid_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [IW-1:0]    winner;
    logic             any_req;
    logic [NREQ-1:0]  winner_onehot;
    logic [WIDTH-1:0] wslice [NREQ];

    rr_picker #(
        .NREQ(NREQ)
    ) u_picker (
        .req_i    (req),
        .rr_ptr_i (rr_ptr_q),
        .winner_o (winner),
        .any_o    (any_req)
    );

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
        assign winner_onehot[gi] = (winner == IW'(gi));
        assign wslice[gi]        = wdata[gi*WIDTH +: WIDTH];
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        gnt_d     = '0;
        q_d       = q_q;
        q_valid_d = q_valid_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d  = GRANT;
                    gnt_d    = winner_onehot;
                    owner_d  = winner;
                    rr_ptr_d = (winner == IW'(NREQ - 1)) ? '0 : winner + 1'b1;
                end
            end
            GRANT: begin
                // Capture regardless of whether the owner still requests.
                q_d       = wslice[owner_q];
                q_valid_d = 1'b1;
                cnt_d     = CW'(HOLD - 1);
                state_d   = HOLDING;
            end
            HOLDING: begin
                if (cnt_q == '0) begin
                    state_d   = IDLE;
                    q_valid_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                q_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            owner_q   <= '0;
            gnt_q     <= '0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            owner_q   <= owner_d;
            gnt_q     <= gnt_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            cnt_q     <= cnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign busy    = (state_q != IDLE);
    assign q       = q_q;
    assign q_valid = q_valid_q;
    assign q_owner = owner_q;

endmodule

// File: tb/tb_dff_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dff_rr_arbiter
// Self-checking bench for dff_rr_arbiter (NREQ=4, WIDTH=8, HOLD=2).
// A transaction-level model predicts each grant (who, when, which data) and
// pushes it into a queue; a negedge monitor pops on grants and checks the
// grant cycle, the HOLD cycles of q_valid, and the idle/retained state.
// ---------------------------------------------------------------------------
module tb_dff_rr_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int HOLD  = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic [WIDTH-1:0]      q;
    logic                  q_valid;
    logic [1:0]            q_owner;

    dff_rr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .HOLD(HOLD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .wdata   (wdata),
        .gnt     (gnt),
        .busy    (busy),
        .q       (q),
        .q_valid (q_valid),
        .q_owner (q_owner)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endfunction

    // ---------------- concurrent assertions ----------------
    a_onehot: assert property (@(posedge clk) $onehot0(gnt))
        else begin failures++; $display("FAIL assert_onehot gnt=%b", gnt); end
    a_gnt_qv: assert property (@(posedge clk) disable iff (!rst_n) (gnt != 0) |=> q_valid)
        else begin failures++; $display("FAIL assert_gnt_then_qvalid q_valid=%b", q_valid); end
    a_qv_busy: assert property (@(posedge clk) q_valid |-> busy)
        else begin failures++; $display("FAIL assert_qvalid_busy busy=%b", busy); end

    // ---------------- reference model (posedge) ----------------
    typedef struct {
        int               edge_no;
        int               owner;
        logic [WIDTH-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   cyc        = 0;
    int   model_ptr  = 0;
    int   free_edge  = 0;
    bit   reset_seen = 0;
    bit   mon_en     = 0;

    always @(posedge clk) begin
        exp_t it;
        int   w;
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            model_ptr  = 0;
            free_edge  = cyc + 1;
            reset_seen = 1;
            mon_en     = 1;
        end else if (cyc >= free_edge && req != 0) begin
            w = -1;
            for (int j = 0; j < NREQ; j++) begin
                if (w < 0 && req[(model_ptr + j) % NREQ]) w = (model_ptr + j) % NREQ;
            end
            it.edge_no = cyc;
            it.owner   = w;
            it.data    = wdata[w*WIDTH +: WIDTH];
            exp_q.push_back(it);
            model_ptr = (w + 1) % NREQ;
            // one GRANT cycle, HOLD cycles of q_valid, one IDLE cycle
            free_edge = cyc + HOLD + 2;
        end
    end

    // ---------------- monitor / scoreboard (negedge) ----------------
    logic [WIDTH-1:0] last_q     = '0;
    int               last_owner = 0;
    int               hold_left  = 0;
    logic [NREQ-1:0]  grant_log[$];

    always @(negedge clk) begin
        exp_t it;
        if (mon_en) begin
            if (reset_seen) begin
                reset_seen = 0;
                hold_left  = 0;
                last_q     = '0;
                last_owner = 0;
            end
            if (gnt != 0 || (exp_q.size() > 0 && exp_q[0].edge_no <= cyc)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_gnt actual=%b expected=0000 t=%0t", gnt, $time);
                end else begin
                    it = exp_q.pop_front();
                    chk("gnt", 32'(gnt), 32'(1) << it.owner);
                    chk("gnt_cycle", cyc, it.edge_no);
                    chk("grant_busy", 32'(busy), 1);
                    chk("grant_qvalid", 32'(q_valid), 0);
                    chk("grant_q_retained", 32'(q), 32'(last_q));
                    grant_log.push_back(gnt);
                    last_q     = it.data;
                    last_owner = it.owner;
                    hold_left  = HOLD;
                end
            end else if (hold_left > 0) begin
                chk("hold_qvalid", 32'(q_valid), 1);
                chk("hold_busy", 32'(busy), 1);
                chk("hold_q", 32'(q), 32'(last_q));
                chk("hold_owner", 32'(q_owner), last_owner);
                hold_left--;
            end else begin
                chk("idle_qvalid", 32'(q_valid), 0);
                chk("idle_busy", 32'(busy), 0);
                chk("idle_q", 32'(q), 32'(last_q));
            end
        end
    end

    // ---------------- stimulus ----------------
    bit auto_drop = 1;
    bit rand_en   = 0;

    task automatic step();
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            if (auto_drop && gnt[i]) req[i] = 1'b0;
            else if (rand_en && !req[i] && !gnt[i] && $urandom_range(0, 3) == 0) begin
                wdata[i*WIDTH +: WIDTH] = WIDTH'($urandom);
                req[i] = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        step();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic run_until(int n, int limit, string nm);
        for (int k = 0; k < limit && grant_log.size() < n; k++) step();
        chk({nm, "_grant_count_reached"}, 32'(grant_log.size() >= n), 1);
    endtask

    task automatic wait_qvalid(string nm);
        int k;
        for (k = 0; k < 20 && !q_valid; k++) step();
        chk({nm, "_qvalid_seen"}, 32'(q_valid), 1);
    endtask

    logic [NREQ-1:0]  ord030[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [NREQ-1:0]  ord031[4] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [WIDTH-1:0] q_before;

    initial begin
        rst_n = 1'b0;
        req   = '0;
        wdata = '0;
        do_reset();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_q", 32'(q), 0);
        chk("rst_qvalid", 32'(q_valid), 0);
        chk("rst_owner", 32'(q_owner), 0);

        // Single requester.
        grant_log.delete();
        wdata[1*WIDTH +: WIDTH] = 8'hA5;
        req = 4'b0010;
        run_until(1, 10, "single");
        wait_qvalid("single");
        chk("single_q", 32'(q), 32'h A5);
        chk("single_owner", 32'(q_owner), 1);
        repeat (4) step();
        chk("single_log_size", grant_log.size(), 1);
        chk("single_log0", 32'(grant_log[0]), 32'b0010);
        $display("single: gnt=%b q=%h", grant_log[0], q);

        // All requesting continuously from rr_ptr=0.
        do_reset();
        grant_log.delete();
        auto_drop = 0;
        req = 4'b1111;
        run_until(5, 40, "all");
        req = '0;
        repeat (6) step();
        chk("all_log_size", grant_log.size(), 5);
        for (int i = 0; i < 5 && i < grant_log.size(); i++)
            chk($sformatf("all_order%0d", i), 32'(grant_log[i]), 32'(ord030[i]));
        $display("all: %0d grants logged", grant_log.size());

        // Wrap: move pointer to 3, then 3 and 0 compete, then pointer at 1.
        grant_log.delete();
        auto_drop = 1;
        wdata[2*WIDTH +: WIDTH] = 8'h11;
        req = 4'b0100;
        run_until(1, 10, "wrap_a");
        auto_drop = 0;
        wdata[3*WIDTH +: WIDTH] = 8'h33;
        wdata[0*WIDTH +: WIDTH] = 8'h00;
        req = 4'b1001;
        run_until(3, 20, "wrap_b");
        req = 4'b0011;
        run_until(4, 20, "wrap_c");
        req = '0;
        repeat (6) step();
        chk("wrap_log_size", grant_log.size(), 4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            chk($sformatf("wrap_order%0d", i), 32'(grant_log[i]), 32'(ord031[i]));
        $display("wrap: %0d grants logged", grant_log.size());

        // Request drops during its own grant cycle; data still captured.
        auto_drop = 1;
        wdata[2*WIDTH +: WIDTH] = 8'h3C;
        req = 4'b0100;
        wait_qvalid("drop");
        chk("drop_req_low", 32'(req[2]), 0);
        chk("drop_q", 32'(q), 32'h3C);
        step();
        chk("drop_qvalid_2nd", 32'(q_valid), 1);
        repeat (4) step();
        $display("drop: q=%h", q);

        // Reset during the first q_valid cycle aborts the transaction.
        wdata[0*WIDTH +: WIDTH] = 8'h5A;
        req = 4'b0001;
        wait_qvalid("rstmid");
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rstmid_q", 32'(q), 0);
        chk("rstmid_qvalid", 32'(q_valid), 0);
        chk("rstmid_busy", 32'(busy), 0);
        chk("rstmid_gnt", 32'(gnt), 0);
        grant_log.delete();
        auto_drop = 0;
        req = 4'b0011;
        run_until(1, 10, "rstmid");
        req = '0;
        chk("rstmid_ptr_zero", 32'(grant_log[0]), 32'b0001);
        auto_drop = 1;
        repeat (6) step();
        $display("rstmid: first grant after reset %b", grant_log[0]);

        // Idle for 20 cycles.
        q_before = q;
        req = '0;
        repeat (20) begin
            step();
            chk("idle_gnt", 32'(gnt), 0);
        end
        chk("idle_q_unchanged", 32'(q), 32'(q_before));
        $display("idle: q=%h", q);

        // Randomized traffic.
        rand_en = 1;
        repeat (600) step();
        rand_en = 0;
        for (int k = 0; k < 60 && req != 0; k++) step();
        repeat (6) step();
        chk("drain_req_clear", 32'(req), 0);
        chk("drain_queue_empty", exp_q.size(), 0);
        $display("random: scoreboard drained, queue=%0d", exp_q.size());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
